clock_sequencer: RTL

CLOCK_SEQUENCER -- requirements
Module: clock_sequencer

---
 rtl/clkseq_pkg.sv | 14 +
 rtl/clkseq_timer.sv | 29 ++
 rtl/clock_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/clkseq_pkg.sv
// Shared types and defaults for the emulated-clock sequencer.
// Only the state encoding and the reset-clear length live here.
package clkseq_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_t;

    localparam int CLRLEN_DEFAULT = 16;

endpackage

// File: rtl/clkseq_timer.sv
// Loadable phase down-counter; a zero load is treated as one so no phase is empty.
// o_tc marks the last cycle of a phase; load takes effect on the next edge. No backpressure.
module clkseq_timer #(
    parameter int            CW     = 12,
    parameter logic [CW-1:0] RSTVAL = '0
) (
    input  logic          i_core_clk,
    input  logic          i_arst_n,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    output logic          o_tc
);

    logic [CW-1:0] r_cnt;

    // The counter parks at zero between phases so o_tc never re-fires while idle.
    always_ff @(posedge i_core_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_cnt <= RSTVAL;
        end else if (i_load) begin
            r_cnt <= (i_load_val == '0) ? CW'(1) : i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_tc = (r_cnt == CW'(1));

endmodule

// File: rtl/clock_sequencer.sv
// Generates the emulated clock T and the _CLR broadcast from the fast clock U.
// T rises one U edge after run/step is seen in IDLE; step outside IDLE is dropped (no queueing).
module clock_sequencer
    import clkseq_pkg::*;
#(
    parameter int CW     = 12,
    parameter int CLRLEN = CLRLEN_DEFAULT,
    parameter int NCW    = 32
) (
    input  logic           U,
    input  logic           _RESET,
    input  logic           run,
    input  logic           step,
    input  logic [CW-1:0]  hilen,
    input  logic [CW-1:0]  lolen,
    output logic           T,
    output logic           _CLR,
    output logic           busy,
    output logic           done,
    output logic [NCW-1:0] ncycles
);

    state_t         r_state;
    logic           r_t;
    logic           r_clr_n;
    logic           r_busy;
    logic           r_done;
    logic [NCW-1:0] r_ncycles;

    logic           w_load;
    logic [CW-1:0]  w_load_val;
    logic           w_tc;

    // The timer is loaded on the same edge that enters HIGH or LOW, so the
    // phase length is sampled exactly at phase entry.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = hilen;
        case (r_state)
            IDLE: begin
                w_load     = run | step;
                w_load_val = hilen;
            end
            HIGH: begin
                w_load     = w_tc;
                w_load_val = lolen;
            end
            LOW: begin
                w_load     = w_tc & run;
                w_load_val = hilen;
            end
            default: begin
                w_load     = 1'b0;
                w_load_val = hilen;
            end
        endcase
    end

    clkseq_timer #(
        .CW     (CW),
        .RSTVAL (CW'(CLRLEN))
    ) u_timer (
        .i_core_clk (U),
        .i_arst_n   (_RESET),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    always_ff @(posedge U or negedge _RESET) begin
        if (!_RESET) begin
            r_state   <= CLEAR;
            r_t       <= 1'b0;
            r_clr_n   <= 1'b0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_ncycles <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                CLEAR: begin
                    if (w_tc) begin
                        r_state <= IDLE;
                        r_clr_n <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (run || step) begin
                        r_state <= HIGH;
                        r_t     <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                HIGH: begin
                    if (w_tc) begin
                        r_state <= LOW;
                        r_t     <= 1'b0;
                    end
                end
                LOW: begin
                    if (w_tc) begin
                        r_done    <= 1'b1;
                        r_ncycles <= r_ncycles + NCW'(1);
                        if (run) begin
                            r_state <= HIGH;
                            r_t     <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= CLEAR;
                    r_t     <= 1'b0;
                    r_clr_n <= 1'b0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign T       = r_t;
    assign _CLR    = r_clr_n;
    assign busy    = r_busy;
    assign done    = r_done;
    assign ncycles = r_ncycles;

endmodule
